// File: rtl/ram2_arbiter.sv
// -----------------------------------------------------------------------------
// ram2_arbiter
//
// Shares the RAM2 SRAM between the instruction-fetch requester (PC stage) and
// the data requester (MEM stage). One access runs at a time. The block drives
// the SRAM strobes with programmable read-wait and write-pulse timing, returns
// read data or write completion through a level-request / one-cycle-ack
// handshake, and raises a pause request while either requester is waiting.
//
// Build option:
//   RAM2_ARB_FAIR_EN  - when defined, a contended grant in IDLE goes to fetch
//                       if the previous grant went to MEM. When undefined,
//                       MEM always wins contention.
//
// Parameters:
//   WAIT_CYCLES  extra cycles OE is held low before read data is sampled (>=0)
//   WE_PULSE     cycles WE is held low per write (>=1)
//
// Ports:
//   rai_clk, rai_rst          memory clock, synchronous active-high reset
//   rai_if_*  / rao_if_*      fetch read request, address, data, ack
//   rai_mem_* / rao_mem_*     data request (read/write), address, data, ack
//   rao_pause_request         stall request to the scheduler
//   rao_ram2_en/oe/we         SRAM strobes, active low
//   rao_ram2_addr/wdata       registered SRAM address and write data
//   rao_ram2_drive            1 = top-level tristate drives rao_ram2_wdata
//   rai_ram2_rdata            SRAM data bus as read back
//   rao_dbg_state             current FSM state, for observation only
//
// Handshake: a requester raises req (level) with address/data stable and holds
// it until it sees ack high for one cycle. Dropping req mid-access does not
// abort it; holding req past ack requests a new access, evaluated in the
// following IDLE cycle.
// -----------------------------------------------------------------------------
module ram2_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int WE_PULSE    = 1
) (
    input  logic        rai_clk,
    input  logic        rai_rst,
    input  logic        rai_if_req,
    input  logic [15:0] rai_if_addr,
    output logic [15:0] rao_if_data,
    output logic        rao_if_ack,
    input  logic        rai_mem_req,
    input  logic        rai_mem_we,
    input  logic [15:0] rai_mem_addr,
    input  logic [15:0] rai_mem_wdata,
    output logic [15:0] rao_mem_rdata,
    output logic        rao_mem_ack,
    output logic        rao_pause_request,
    output logic        rao_ram2_en,
    output logic        rao_ram2_oe,
    output logic        rao_ram2_we,
    output logic [15:0] rao_ram2_addr,
    output logic [15:0] rao_ram2_wdata,
    output logic        rao_ram2_drive,
    input  logic [15:0] rai_ram2_rdata,
    output logic [2:0]  rao_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_RESP    = 3'd2,
        S_W_SETUP = 3'd3,
        S_W_PULSE = 3'd4,
        S_W_HOLD  = 3'd5
    } state_t;

    // One down-counter serves both the read wait and the write pulse.
    localparam int CNT_MAX = (WAIT_CYCLES > (WE_PULSE - 1)) ? WAIT_CYCLES : (WE_PULSE - 1);
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(WE_PULSE - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [15:0]        r_addr;
    logic [15:0]        r_wdata;
    logic [15:0]        r_if_data;
    logic [15:0]        r_mem_rdata;
    logic               r_owner_mem;   // 0 = IF owns the access, 1 = MEM
    logic               w_sel_mem;
    logic               w_grant;
    logic               w_grant_mem;
    logic               w_cnt_done;

`ifdef RAM2_ARB_FAIR_EN
    logic               r_last_mem;    // previous grant went to MEM

    // Contention goes to fetch only when MEM had the previous grant.
    assign w_sel_mem = rai_mem_req & ~(rai_if_req & r_last_mem);
`else
    assign w_sel_mem = rai_mem_req;
`endif

    assign w_cnt_done = (r_cnt == '0);

    // Next-state and strobe decode.
    always_comb begin
        w_next_state   = r_state;
        w_grant        = 1'b0;
        w_grant_mem    = 1'b0;
        rao_ram2_en    = 1'b1;
        rao_ram2_oe    = 1'b1;
        rao_ram2_we    = 1'b1;
        rao_ram2_drive = 1'b0;
        rao_if_ack     = 1'b0;
        rao_mem_ack    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rai_mem_req | rai_if_req) begin
                    w_grant      = 1'b1;
                    w_grant_mem  = w_sel_mem;
                    w_next_state = (w_sel_mem & rai_mem_we) ? S_W_SETUP : S_READ;
                end
            end
            S_READ: begin
                rao_ram2_en = 1'b0;
                rao_ram2_oe = 1'b0;
                if (w_cnt_done) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                rao_ram2_en  = 1'b0;
                rao_if_ack   = ~r_owner_mem;
                rao_mem_ack  = r_owner_mem;
                w_next_state = S_IDLE;
            end
            S_W_SETUP: begin
                rao_ram2_en    = 1'b0;
                rao_ram2_drive = 1'b1;
                w_next_state   = S_W_PULSE;
            end
            S_W_PULSE: begin
                rao_ram2_en    = 1'b0;
                rao_ram2_we    = 1'b0;
                rao_ram2_drive = 1'b1;
                if (w_cnt_done) begin
                    w_next_state = S_W_HOLD;
                end
            end
            S_W_HOLD: begin
                rao_ram2_en    = 1'b0;
                rao_ram2_drive = 1'b1;
                rao_mem_ack    = 1'b1;
                w_next_state   = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge rai_clk) begin
        if (rai_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_if_data   <= '0;
            r_mem_rdata <= '0;
            r_owner_mem <= 1'b0;
`ifdef RAM2_ARB_FAIR_EN
            r_last_mem  <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            if (w_grant) begin
                r_addr      <= w_grant_mem ? rai_mem_addr : rai_if_addr;
                r_owner_mem <= w_grant_mem;
                r_cnt       <= READ_LOAD;
                if (w_grant_mem & rai_mem_we) begin
                    r_wdata <= rai_mem_wdata;
                end
`ifdef RAM2_ARB_FAIR_EN
                r_last_mem  <= w_grant_mem;
`endif
            end
            case (r_state)
                S_READ: begin
                    // Sample the bus at the end of the last OE-low cycle.
                    if (w_cnt_done) begin
                        if (r_owner_mem) begin
                            r_mem_rdata <= rai_ram2_rdata;
                        end else begin
                            r_if_data <= rai_ram2_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_W_SETUP: begin
                    r_cnt <= PULSE_LOAD;
                end
                S_W_PULSE: begin
                    if (!w_cnt_done) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rao_ram2_addr  = r_addr;
    assign rao_ram2_wdata = r_wdata;
    assign rao_if_data    = r_if_data;
    assign rao_mem_rdata  = r_mem_rdata;
    assign rao_dbg_state  = r_state;

    // A requester stops asking for a stall in its own ack cycle.
    assign rao_pause_request = ~rai_rst &
                               ((rai_mem_req & ~rao_mem_ack) | (rai_if_req & ~rao_if_ack));

endmodule

// File: tb/tb_ram2_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram2_arbiter
//
// Bench for ram2_arbiter. A behavioural SRAM sits on the RAM2 pins. Drivers
// push the expected response for each access into per-port queues; a monitor
// on the falling edge pops and compares whenever an ack is presented. Directed
// cycle traces cover latency, strobe shapes, arbitration and reset; a random
// phase runs both requesters concurrently against a reference memory.
// -----------------------------------------------------------------------------
module tb_ram2_arbiter;

    localparam int P_WAIT = 1;
    localparam int P_WE   = 1;
    localparam int R_LAT  = P_WAIT + 2;  // read ack cycle after request
    localparam int W_LAT  = P_WE + 2;    // write ack cycle after request

    // ---------------- clock / reset ----------------
    logic rai_clk = 1'b0;
    logic rai_rst = 1'b1;
    always #5 rai_clk = ~rai_clk;

    int tb_cyc = 0;
    always @(posedge rai_clk) tb_cyc <= tb_cyc + 1;

    // ---------------- DUT ----------------
    logic        rai_if_req = 1'b0;
    logic [15:0] rai_if_addr = '0;
    logic [15:0] rao_if_data;
    logic        rao_if_ack;
    logic        rai_mem_req = 1'b0;
    logic        rai_mem_we = 1'b0;
    logic [15:0] rai_mem_addr = '0;
    logic [15:0] rai_mem_wdata = '0;
    logic [15:0] rao_mem_rdata;
    logic        rao_mem_ack;
    logic        rao_pause_request;
    logic        rao_ram2_en, rao_ram2_oe, rao_ram2_we, rao_ram2_drive;
    logic [15:0] rao_ram2_addr, rao_ram2_wdata, rai_ram2_rdata;
    logic [2:0]  rao_dbg_state;

    ram2_arbiter #(.WAIT_CYCLES(P_WAIT), .WE_PULSE(P_WE)) dut (
        .rai_clk(rai_clk), .rai_rst(rai_rst),
        .rai_if_req(rai_if_req), .rai_if_addr(rai_if_addr),
        .rao_if_data(rao_if_data), .rao_if_ack(rao_if_ack),
        .rai_mem_req(rai_mem_req), .rai_mem_we(rai_mem_we),
        .rai_mem_addr(rai_mem_addr), .rai_mem_wdata(rai_mem_wdata),
        .rao_mem_rdata(rao_mem_rdata), .rao_mem_ack(rao_mem_ack),
        .rao_pause_request(rao_pause_request),
        .rao_ram2_en(rao_ram2_en), .rao_ram2_oe(rao_ram2_oe), .rao_ram2_we(rao_ram2_we),
        .rao_ram2_addr(rao_ram2_addr), .rao_ram2_wdata(rao_ram2_wdata),
        .rao_ram2_drive(rao_ram2_drive), .rai_ram2_rdata(rai_ram2_rdata),
        .rao_dbg_state(rao_dbg_state)
    );

    // ---------------- behavioural SRAM and reference memory ----------------
    logic [15:0] sram    [65536];
    logic [15:0] ref_mem [65536];

    assign rai_ram2_rdata = (!rao_ram2_en && !rao_ram2_oe) ? sram[rao_ram2_addr] : 16'hDEAD;

    always @(negedge rai_clk) begin
        if (!rao_ram2_en && !rao_ram2_we && rao_ram2_drive) sram[rao_ram2_addr] = rao_ram2_wdata;
    end

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_pass  = 0;
    int viol    = 0;
    logic [15:0] exp_if_q[$];
    logic [16:0] exp_mem_q[$];   // bit 16 = write (no data compare)
    logic [15:0] mon_if_e;
    logic [16:0] mon_mem_e;
    logic [15:0] prev_addr, prev_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge rai_clk) begin
        if (!rai_rst) begin
            if (rao_if_ack) begin
                if (exp_if_q.size() == 0) check("if_ack_unexpected", 1, 0);
                else begin
                    mon_if_e = exp_if_q.pop_front();
                    check("if_rdata", rao_if_data, mon_if_e);
                end
            end
            if (rao_mem_ack) begin
                if (exp_mem_q.size() == 0) check("mem_ack_unexpected", 1, 0);
                else begin
                    mon_mem_e = exp_mem_q.pop_front();
                    if (!mon_mem_e[16]) check("mem_rdata", rao_mem_rdata, mon_mem_e[15:0]);
                end
            end
            if (!rao_ram2_oe && !rao_ram2_we) viol++;
            if (rao_ram2_drive && !rao_ram2_oe) viol++;
            if (!rao_ram2_we && (rao_ram2_addr != prev_addr || rao_ram2_wdata != prev_wdata)) viol++;
        end
        prev_addr  = rao_ram2_addr;
        prev_wdata = rao_ram2_wdata;
    end

    // ---------------- driver tasks ----------------
    task automatic reset_dut();
        rai_rst = 1'b1;
        repeat (2) @(posedge rai_clk);
        #1 rai_rst = 1'b0;
    endtask

    task automatic if_read(input logic [15:0] a, output int ack_cyc);
        rai_if_addr = a;
        rai_if_req  = 1'b1;
        exp_if_q.push_back(ref_mem[a]);
        ack_cyc = -1;
        for (int n = 0; n < 64; n++) begin
            @(negedge rai_clk);
            if (rao_if_ack) begin
                ack_cyc = tb_cyc;
                break;
            end
        end
        rai_if_req = 1'b0;
        if (ack_cyc < 0) check("if_ack_timeout", 0, 1);
    endtask

    task automatic mem_access(input logic we, input logic [15:0] a, input logic [15:0] d,
                              output int ack_cyc);
        rai_mem_we    = we;
        rai_mem_addr  = a;
        rai_mem_wdata = d;
        rai_mem_req   = 1'b1;
        exp_mem_q.push_back({we, we ? 16'h0000 : ref_mem[a]});
        if (we) ref_mem[a] = d;
        ack_cyc = -1;
        for (int n = 0; n < 64; n++) begin
            @(negedge rai_clk);
            if (rao_mem_ack) begin
                ack_cyc = tb_cyc;
                break;
            end
        end
        rai_mem_req = 1'b0;
        if (ack_cyc < 0) check("mem_ack_timeout", 0, 1);
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] tr_oe, tr_en, tr_we, tr_drv, tr_ack, tr_pause, tr_stable;
    logic [15:0] ex_oe, ex_en, ex_we, ex_drv, ex_ack, ex_pause;
    logic [15:0] d_at;
    int c0, a_if, a_m1, a_m2, ack_cnt, ack_at, en_low_after;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            sram[i]    = 16'(i) ^ 16'h5A5A;
            ref_mem[i] = 16'(i) ^ 16'h5A5A;
        end
        sram[16'h0040]    = 16'h4A11;
        ref_mem[16'h0040] = 16'h4A11;

        // Reset state, with both requests asserted during reset.
        rai_if_req  = 1'b1;
        rai_mem_req = 1'b1;
        repeat (3) @(posedge rai_clk);
        @(negedge rai_clk);
        check("rst_strobes_en_oe_we_drive",
              {rao_ram2_en, rao_ram2_oe, rao_ram2_we, rao_ram2_drive}, 4'b1110);
        check("rst_addr", rao_ram2_addr, 16'h0000);
        check("rst_wdata", rao_ram2_wdata, 16'h0000);
        check("rst_if_data", rao_if_data, 16'h0000);
        check("rst_mem_rdata", rao_mem_rdata, 16'h0000);
        check("rst_acks", {rao_if_ack, rao_mem_ack}, 2'b00);
        check("rst_pause", rao_pause_request, 1'b0);
        rai_if_req  = 1'b0;
        rai_mem_req = 1'b0;
        reset_dut();

        // Fetch read of 0x0040: cycle trace of strobes, ack and pause.
        @(posedge rai_clk); #1;
        tr_oe = '0; tr_en = '0; tr_ack = '0; tr_pause = '0; d_at = '0;
        ex_oe = '0; ex_en = '0; ex_ack = '0; ex_pause = '0;
        rai_if_addr = 16'h0040;
        rai_if_req  = 1'b1;
        exp_if_q.push_back(ref_mem[16'h0040]);
        for (int k = 0; k <= R_LAT; k++) begin
            @(negedge rai_clk);
            tr_oe[k] = rao_ram2_oe; tr_en[k] = rao_ram2_en;
            tr_ack[k] = rao_if_ack; tr_pause[k] = rao_pause_request;
            if (rao_if_ack) begin
                d_at = rao_if_data;
                rai_if_req = 1'b0;
            end
            ex_oe[k]    = !(k >= 1 && k <= P_WAIT + 1);
            ex_en[k]    = (k == 0);
            ex_ack[k]   = (k == R_LAT);
            ex_pause[k] = (k < R_LAT);
        end
        rai_if_req = 1'b0;
        check("rd_oe_trace", tr_oe, ex_oe);
        check("rd_en_trace", tr_en, ex_en);
        check("rd_ack_trace", tr_ack, ex_ack);
        check("rd_pause_trace", tr_pause, ex_pause);
        check("rd_data_at_ack", d_at, 16'h4A11);
        repeat (3) @(negedge rai_clk);
        check("rd_data_held", rao_if_data, 16'h4A11);

        // MEM write 0x1234 to 0x8000.
        @(posedge rai_clk); #1;
        tr_oe = '0; tr_en = '0; tr_we = '0; tr_drv = '0; tr_ack = '0; tr_stable = '0;
        ex_oe = '0; ex_en = '0; ex_we = '0; ex_drv = '0; ex_ack = '0;
        rai_mem_we = 1'b1; rai_mem_addr = 16'h8000; rai_mem_wdata = 16'h1234;
        rai_mem_req = 1'b1;
        exp_mem_q.push_back({1'b1, 16'h0000});
        ref_mem[16'h8000] = 16'h1234;
        for (int k = 0; k <= W_LAT; k++) begin
            @(negedge rai_clk);
            tr_oe[k] = rao_ram2_oe; tr_en[k] = rao_ram2_en; tr_we[k] = rao_ram2_we;
            tr_drv[k] = rao_ram2_drive; tr_ack[k] = rao_mem_ack;
            tr_stable[k] = (rao_ram2_addr == 16'h8000) && (rao_ram2_wdata == 16'h1234);
            if (rao_mem_ack) rai_mem_req = 1'b0;
            ex_oe[k]  = 1'b1;
            ex_en[k]  = (k == 0);
            ex_we[k]  = !(k >= 2 && k <= P_WE + 1);
            ex_drv[k] = (k >= 1);
            ex_ack[k] = (k == W_LAT);
        end
        rai_mem_req = 1'b0;
        check("wr_oe_trace", tr_oe, ex_oe);
        check("wr_en_trace", tr_en, ex_en);
        check("wr_we_trace", tr_we, ex_we);
        check("wr_drive_trace", tr_drv, ex_drv);
        check("wr_ack_trace", tr_ack, ex_ack);
        check("wr_addr_data_stable", tr_stable & ex_drv, ex_drv);

        // MEM read of 0x8000 with req dropped during READ.
        @(posedge rai_clk); #1;
        rai_mem_we = 1'b0; rai_mem_addr = 16'h8000; rai_mem_req = 1'b1;
        exp_mem_q.push_back({1'b0, ref_mem[16'h8000]});
        ack_cnt = 0; ack_at = -1; en_low_after = 0;
        for (int k = 0; k <= R_LAT + 6; k++) begin
            @(negedge rai_clk);
            if (k == 1) rai_mem_req = 1'b0;
            if (rao_mem_ack) begin
                ack_cnt++;
                ack_at = k;
            end
            if (k > R_LAT && !rao_ram2_en) en_low_after++;
        end
        check("drop_ack_count", ack_cnt, 1);
        check("drop_ack_cycle", ack_at, R_LAT);
        check("drop_no_second_access", en_low_after, 0);

        // Contention: fetch and MEM read together, MEM re-requesting once.
        reset_dut();
        c0 = tb_cyc;
        fork
            begin
                if_read(16'h0010, a_if);
            end
            begin
                mem_access(1'b0, 16'h8001, 16'h0000, a_m1);
                mem_access(1'b0, 16'h8002, 16'h0000, a_m2);
            end
        join
        check("cont_mem1_ack_cycle", a_m1 - c0, R_LAT);
`ifdef RAM2_ARB_FAIR_EN
        check("cont_if_ack_cycle", a_if - c0, 2 * R_LAT + 1);
        check("cont_mem2_ack_cycle", a_m2 - c0, 3 * R_LAT + 2);
`else
        check("cont_if_ack_cycle", a_if - c0, 3 * R_LAT + 2);
        check("cont_mem2_ack_cycle", a_m2 - c0, 2 * R_LAT + 1);
`endif

        // Reset during the write pulse, then a normal fetch.
        @(posedge rai_clk); #1;
        rai_mem_we = 1'b1; rai_mem_addr = 16'h9000; rai_mem_wdata = 16'hBEEF;
        rai_mem_req = 1'b1;
        repeat (3) @(negedge rai_clk);
        check("rstw_we_low_in_pulse", rao_ram2_we, 1'b0);
        rai_rst = 1'b1;
        @(negedge rai_clk);
        check("rstw_strobes_en_we_drive", {rao_ram2_en, rao_ram2_we, rao_ram2_drive}, 3'b110);
        check("rstw_no_ack", rao_mem_ack, 1'b0);
        check("rstw_pause", rao_pause_request, 1'b0);
        rai_mem_req = 1'b0;
        rai_mem_we  = 1'b0;
        @(posedge rai_clk); #1 rai_rst = 1'b0;
        @(posedge rai_clk); #1;
        c0 = tb_cyc;
        if_read(16'h0041, a_if);
        check("rstw_fetch_after_reset", a_if - c0, R_LAT);

        // Random concurrent traffic.
        fork
            begin
                logic [15:0] a;
                int ac;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge rai_clk);
                    #1;
                    a = 16'($urandom_range(0, 255));
                    if_read(a, ac);
                end
            end
            begin
                logic [15:0] a;
                logic [15:0] d;
                logic        w;
                int ac;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge rai_clk);
                    #1;
                    a = 16'h8000 | 16'($urandom_range(0, 255));
                    d = 16'($urandom);
                    w = 1'($urandom_range(0, 1));
                    mem_access(w, a, d, ac);
                end
            end
        join
        repeat (5) @(posedge rai_clk);

        check("protocol_violations", viol, 0);
        check("if_queue_drained", exp_if_q.size(), 0);
        check("mem_queue_drained", exp_mem_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram2_arbiter.md
# ram2_arbiter

Sequences and shares the RAM2 SRAM between the instruction-fetch requester (PC stage) and the data requester (MEM stage). It serialises their accesses and generates the SRAM control strobes with programmable read-wait and write-pulse timing. It returns read data or write completion through a request/acknowledge handshake, and raises a pause request to the scheduler while any access is outstanding. It runs on the fast memory clock and replaces ad-hoc RAM2 bus muxing in the top level.

## Interface
Parameters:
- WAIT_CYCLES, 1: extra cycles OE is held low before read data is sampled (≥0).
- WE_PULSE, 1: cycles WE is held low per write (≥1).

Ports (reset is synchronous and active-high):
- rai_clk  in  1  memory clock (50 MHz domain).
- rai_rst  in  1  synchronous active-high reset.
- rai_if_req  in  1  fetch read request; level, held until ack.
- rai_if_addr  in  16  fetch address; stable while req high.
- rao_if_data  out  16  fetch read data; valid in ack cycle, held after.
- rao_if_ack  out  1  one-cycle fetch completion pulse.
- rai_mem_req  in  1  data request; level, held until ack.
- rai_mem_we  in  1  1 = write, 0 = read; stable while req high.
- rai_mem_addr  in  16  data address.
- rai_mem_wdata  in  16  write data.
- rao_mem_rdata  out  16  data read result; valid in ack cycle, held after.
- rao_mem_ack  out  1  one-cycle data completion pulse.
- rao_pause_request  out  1  pipeline stall request to scheduler.
- rao_ram2_en  out  1  SRAM chip enable, active low.
- rao_ram2_oe  out  1  SRAM output enable, active low.
- rao_ram2_we  out  1  SRAM write enable, active low.
- rao_ram2_addr  out  16  SRAM address, registered.
- rao_ram2_wdata  out  16  data to drive onto the bus.
- rao_ram2_drive  out  1  1 = top-level tristate drives rao_ram2_wdata onto the data bus.
- rai_ram2_rdata  in  16  data bus as read back.

## Operation
States: IDLE, READ, RESP, W_SETUP, W_PULSE, W_HOLD. The owner register records the granted requester (IF or MEM).

- IDLE: en=1, oe=1, we=1, drive=0. On any pending request, grant per the arbitration rule, latch addr (and wdata for writes) into output registers, and set owner.
  - Fetch and MEM reads go to READ.
  - MEM writes go to W_SETUP.
- READ: en=0, oe=0. Stays WAIT_CYCLES+1 cycles, counted by a down-counter. At the end of the last cycle, latch rai_ram2_rdata into the owner's rdata register. Then go to RESP.
- RESP: oe=1, en=0. Owner's ack=1. Then go to IDLE.
- W_SETUP: en=0, we=1, drive=1. One cycle, then W_PULSE.
- W_PULSE: we=0, drive=1. Lasts WE_PULSE cycles, then W_HOLD.
- W_HOLD: we=1, drive=1, mem ack=1. Then go to IDLE.

Arbitration:
- MEM has priority over fetch when both are pending in IDLE.
- The request-to-grant decision is made only in IDLE. An access in progress is never pre-empted.

Handshake and pause:
- A requester dropping req mid-access does not abort the access; the ack still pulses and may be ignored.
- A requester keeping req high after ack is treated as a new access, evaluated in the following IDLE cycle.
- rao_pause_request = (rai_mem_req & ~rao_mem_ack) | (rai_if_req & ~rao_if_ack). Combinational; forced 0 while rai_rst is high.

## Timing
- Reset values: state IDLE; en=1, oe=1, we=1, drive=0; addr=0, wdata=0; both rdata=0; both acks=0; owner=IF.
- Reset mid-access: strobes return to inactive at the next edge. No ack is issued. An interrupted write is undefined in SRAM.
- Read latency (req seen in IDLE at cycle 0): ack in cycle WAIT_CYCLES+2. The default gives ack at cycle 3.
- Write latency: ack in cycle WE_PULSE+2. The default gives ack at cycle 3.
- At least one IDLE cycle separates consecutive accesses.
- Address and write data are stable from W_SETUP through W_HOLD, so WE never toggles with the address or data changing.
- oe and we are never low in the same cycle.
- drive is never 1 while oe=0.

## Configuration
- RAM2_ARB_FAIR_EN defined: when both requests are pending in IDLE and the previous grant was MEM, fetch wins. Otherwise MEM wins. A last-grant flag is reset to IF, so the first contention goes to MEM.
- Not defined: strict MEM priority. Fetch can starve while MEM requests back-to-back.

## Test plan
- Fetch read, addr 0x0040, SRAM returns 0x4A11 → oe low cycles 1–2, rao_if_ack in cycle 3 with rao_if_data=0x4A11, pause high cycles 0–2.
- MEM write 0x1234 to 0x8000 → W_SETUP cycle 1, we=0 cycle 2, ack cycle 3; addr and wdata stable and drive=1 in cycles 1–3.
- Simultaneous fetch and MEM read in cycle 0 → MEM acks cycle 3, fetch acks cycle 7. With RAM2_ARB_FAIR_EN and MEM re-requesting: the next contention goes to fetch.
- WAIT_CYCLES=3, WE_PULSE=2 → read ack at cycle 5, write ack at cycle 4, with we low exactly 2 cycles.
- rai_rst asserted during W_PULSE → next cycle we=1, en=1, drive=0, no ack, pause=0. After reset release, a fetch proceeds normally.
- MEM req dropped during READ → ack still pulses once, state returns to IDLE, and no second access is started.
